// File: rtl/jtframe_pocket_dump.sv
// jtframe_pocket_dump: Analogue Pocket bridge read responder for game memory dumps.
// A hit on the dump window makes the block fetch four bytes from the game through
// the ioctl read port (dump_addr -> dump_din) and present them as one big-endian
// word on bridge_rd_data.
// Optional feature: define JTFRAME_POCKET_PREFETCH_EN to fetch the following word
// in the background after each answered read, so sequential reads complete in one cycle.
module jtframe_pocket_dump #(
  parameter logic [31:0] BASE   = 32'h2000_0000,
  parameter int          ADDRW  = 17,
  parameter int          DINLAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      bridge_addr,
  input  logic             bridge_rd,
  output logic [31:0]      bridge_rd_data,
  output logic             rd_busy,
  output logic             rd_drop,
  output logic [ADDRW-1:0] dump_addr,
  output logic             dump_rd,
  input  logic [7:0]       dump_din,
  output logic             dump_active
);

  localparam logic [1:0] LAST_WAIT = 2'(DINLAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [ADDRW-1:0] wa, req_wa;
  logic [1:0]       k, cnt;
  logic [31:0]      shadow, shadow_cap;
  logic             hit, req, wait_last;
  logic             start_fetch, next_byte, capture, present, set_drop;

`ifdef JTFRAME_POCKET_PREFETCH_EN
  logic [31:0]      pf_word;
  logic             pf_valid, pf_mode, pf_claim;
  logic             pf_tgt, pf_claim_set, pf_abort;
  logic             start_pf, pf_take, pf_store;
`endif

  assign hit         = bridge_addr[31:ADDRW] == BASE[31:ADDRW];
  assign req         = bridge_rd & hit;
  assign req_wa      = {bridge_addr[ADDRW-1:2], 2'b00};
  assign wait_last   = (state == WAIT) && (cnt == LAST_WAIT);
  assign dump_active = state != IDLE;

`ifdef JTFRAME_POCKET_PREFETCH_EN
  // While a background prefetch runs (rd_busy low), a hit either claims it or aborts it.
  assign pf_tgt       = req_wa == wa;
  assign pf_claim_set = req && !rd_busy && pf_mode && pf_tgt;
  assign pf_abort     = req && !rd_busy && pf_mode && !pf_tgt;
`endif

  // Merge the incoming byte into its big-endian lane of the shadow word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shadow_cap = shadow;
    case (k)
      2'd0:    shadow_cap[31:24] = dump_din;
      2'd1:    shadow_cap[23:16] = dump_din;
      2'd2:    shadow_cap[15:8]  = dump_din;
      default: shadow_cap[7:0]   = dump_din;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and the one-cycle control strobes for the datapath.
  always_comb begin
    state_nxt   = state;
    start_fetch = 1'b0;
    next_byte   = 1'b0;
    capture     = 1'b0;
    present     = 1'b0;
    set_drop    = req && rd_busy;
`ifdef JTFRAME_POCKET_PREFETCH_EN
    start_pf    = 1'b0;
    pf_take     = 1'b0;
    pf_store    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = ISSUE;
`ifdef JTFRAME_POCKET_PREFETCH_EN
          if (pf_valid && pf_tgt) begin
            pf_take  = 1'b1;
            start_pf = 1'b1;
          end else begin
            start_fetch = 1'b1;
          end
`else
          start_fetch = 1'b1;
`endif
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (wait_last) begin
          capture = 1'b1;
          if (k != 2'd3) begin
            next_byte = 1'b1;
            state_nxt = ISSUE;
          end
`ifdef JTFRAME_POCKET_PREFETCH_EN
          else if (pf_mode && !pf_claim && !pf_claim_set) begin
            pf_store  = 1'b1;
            state_nxt = IDLE;
          end
`endif
          else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        present = 1'b1;
`ifdef JTFRAME_POCKET_PREFETCH_EN
        start_pf  = 1'b1;
        state_nxt = ISSUE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
`ifdef JTFRAME_POCKET_PREFETCH_EN
    // A read of a different word wins over the background prefetch.
    if (pf_abort) begin
      start_fetch = 1'b1;
      capture     = 1'b0;
      next_byte   = 1'b0;
      pf_store    = 1'b0;
      state_nxt   = ISSUE;
    end
`endif
  end

  // Datapath: byte addressing, word assembly and bridge-facing registers.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register sees pre-edge values of the others.
    if (!rst_n) begin
      wa             <= '0;
      k              <= '0;
      cnt            <= '0;
      shadow         <= '0;
      bridge_rd_data <= '0;
      rd_busy        <= 1'b0;
      rd_drop        <= 1'b0;
      dump_addr      <= '0;
      dump_rd        <= 1'b0;
`ifdef JTFRAME_POCKET_PREFETCH_EN
      pf_word        <= '0;
      pf_valid       <= 1'b0;
      pf_mode        <= 1'b0;
      pf_claim       <= 1'b0;
`endif
    end else begin
      dump_rd <= 1'b0;
      cnt     <= (state == WAIT) ? cnt + 2'd1 : 2'd0;
      if (capture) shadow <= shadow_cap;
      if (next_byte) begin
        k         <= k + 2'd1;
        dump_addr <= wa + ADDRW'(k) + ADDRW'(1);
        dump_rd   <= 1'b1;
      end
      if (present) begin
        bridge_rd_data <= shadow;
        rd_busy        <= 1'b0;
      end
      if (set_drop) rd_drop <= 1'b1;
      if (start_fetch) begin
        wa        <= req_wa;
        k         <= '0;
        rd_busy   <= 1'b1;
        dump_addr <= req_wa;
        dump_rd   <= 1'b1;
      end
`ifdef JTFRAME_POCKET_PREFETCH_EN
      if (start_pf) begin
        wa        <= wa + ADDRW'(4);
        k         <= '0;
        dump_addr <= wa + ADDRW'(4);
        dump_rd   <= 1'b1;
        pf_mode   <= 1'b1;
        pf_valid  <= 1'b0;
      end
      if (start_fetch) begin
        pf_mode  <= 1'b0;
        pf_valid <= 1'b0;
        pf_claim <= 1'b0;
      end
      if (pf_take) bridge_rd_data <= pf_word;
      if (pf_store) begin
        pf_word  <= shadow_cap;
        pf_valid <= 1'b1;
        pf_mode  <= 1'b0;
      end
      if (pf_claim_set) begin
        pf_claim <= 1'b1;
        rd_busy  <= 1'b1;
      end
      if (present) pf_claim <= 1'b0;
`endif
    end
  end

endmodule
